// File: rtl/pcileech_com_tx_arbiter.sv
// Four-requester round-robin arbiter that packs 32-bit words into 256-bit COM writes.
// A partial pack is padded with PARAM_FILL and flushed after PARAM_FLUSH_TICKS idle cycles.
module pcileech_com_tx_arbiter #(
    parameter int unsigned PARAM_BURST       = 8,
    parameter int unsigned PARAM_FLUSH_TICKS = 256,
    parameter logic [31:0] PARAM_FILL        = 32'h66665555
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] req_data,
    input  logic [3:0]   req_valid,
    output logic [3:0]   req_ack,
    output logic [255:0] com_din,
    output logic         com_din_wr_en,
    input  logic         com_din_ready,
    output logic [1:0]   grant_id,
    output logic         busy
);

    // state   | meaning
    // S_IDLE  | no grant held; round-robin pick among valid requesters
    // S_GRANT | accepting words from grant_q until burst end or valid drops
    // S_FLUSH | pad partial pack with filler and hand it to the output register
    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_FLUSH} state_t;

    localparam logic [7:0]  BURST_LAST = 8'(PARAM_BURST - 1);
    localparam logic [15:0] TICK_LAST  = 16'(PARAM_FLUSH_TICKS - 1);

    state_t         state_q, state_d;
    logic [2:0]     cnt_q, cnt_d;
    logic [15:0]    timer_q, timer_d;
    logic [7:0]     burst_q, burst_d;
    logic [1:0]     last_q, last_d;
    logic [1:0]     grant_q, grant_d;
    logic [255:0]   pack_q, pack_d;
    logic           pend_q, pend_d;
    logic [255:0]   out_q, out_d;
    logic           out_valid_q, out_valid_d;

    logic           out_pop;
    logic           out_free;
    logic           slot_ok;
    logic           accept;
    logic           timeout;
    logic [31:0]    word;
    logic [255:0]   flush_pack;
    logic           found;
    logic [1:0]     pick;
    logic [1:0]     idx;

    assign out_pop  = out_valid_q && com_din_ready;
    assign out_free = !out_valid_q || com_din_ready;
    // Lane 7 only completes a pack if the output register will be empty by the transfer edge.
    assign slot_ok  = !((cnt_q == 3'd7) && !out_free) && !(pend_q && !out_free);
    assign word     = req_data[{grant_q, 5'd0} +: 32];
    assign accept   = !rst && (state_q == S_GRANT) && req_valid[grant_q] && slot_ok;
    assign timeout  = (cnt_q != 3'd0) && (timer_q == TICK_LAST) && !accept;

    assign req_ack       = accept ? (4'b0001 << grant_q) : 4'b0000;
    assign com_din_wr_en = !rst && out_pop;
    assign com_din       = out_q;
    assign grant_id      = grant_q;
    assign busy          = !rst && ((cnt_q != 3'd0) || out_valid_q || pend_q || (state_q == S_FLUSH));

    always_comb begin
        pick  = last_q;
        found = 1'b0;
        idx   = last_q;
        for (int k = 1; k <= 4; k++) begin
            idx = last_q + 2'(k);
            if (!found && req_valid[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        flush_pack = pack_q;
        for (int i = 0; i < 8; i++) begin
            if (3'(i) >= cnt_q) begin
                flush_pack[32*i +: 32] = PARAM_FILL;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        timer_d     = timer_q;
        burst_d     = burst_q;
        last_d      = last_q;
        grant_d     = grant_q;
        pack_d      = pack_q;
        pend_d      = pend_q;
        out_d       = out_q;
        out_valid_d = out_valid_q && !out_pop;

        if (pend_q && out_free) begin
            out_d       = pack_q;
            out_valid_d = 1'b1;
            pend_d      = 1'b0;
        end

        if (accept) begin
            pack_d[{cnt_q, 5'd0} +: 32] = word;
            cnt_d   = cnt_q + 3'd1;
            timer_d = 16'd0;
            if (cnt_q == 3'd7) begin
                pend_d = 1'b1;
            end
        end else if (cnt_q == 3'd0) begin
            timer_d = 16'd0;
        end else begin
            timer_d = timer_q + 16'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (timeout) begin
                    state_d = S_FLUSH;
                end else if (found) begin
                    grant_d = pick;
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                if (accept) begin
                    burst_d = burst_q + 8'd1;
                    if (burst_q == BURST_LAST) begin
                        burst_d = 8'd0;
                        last_d  = grant_q;
                        state_d = S_IDLE;
                    end
                end else if (timeout) begin
                    burst_d = 8'd0;
                    last_d  = grant_q;
                    state_d = S_FLUSH;
                end else if (!req_valid[grant_q]) begin
                    burst_d = 8'd0;
                    last_d  = grant_q;
                    state_d = S_IDLE;
                end
            end
            S_FLUSH: begin
                if (out_free) begin
                    out_d       = flush_pack;
                    out_valid_d = 1'b1;
                    cnt_d       = 3'd0;
                    timer_d     = 16'd0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 3'd0;
            timer_q     <= 16'd0;
            burst_q     <= 8'd0;
            last_q      <= 2'd3;
            grant_q     <= 2'd0;
            pack_q      <= '0;
            pend_q      <= 1'b0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            timer_q     <= timer_d;
            burst_q     <= burst_d;
            last_q      <= last_d;
            grant_q     <= grant_d;
            pack_q      <= pack_d;
            pend_q      <= pend_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_pcileech_com_tx_arbiter.sv
// Bench for pcileech_com_tx_arbiter: instance A uses default parameters, instance B uses
// burst 2 / flush after 16 ticks; sel routes the shared stimulus to one of them.
module tb_pcileech_com_tx_arbiter;

    localparam logic [31:0] FILL = 32'h66665555;

    typedef struct {
        int          req;
        logic [31:0] base;
        logic [1:0]  exp_gid;
        int          exp_writes;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         sel;
    logic [127:0] req_data;
    logic [3:0]   req_valid;
    logic         com_din_ready;

    logic [3:0]   req_valid_a, req_valid_b;
    logic [3:0]   ack_a, ack_b, ack;
    logic [255:0] din_a, din_b, din;
    logic         wr_a, wr_b, wr_en;
    logic [1:0]   gid_a, gid_b, gid;
    logic         busy_a, busy_b, busy;

    assign req_valid_a = sel ? 4'b0000 : req_valid;
    assign req_valid_b = sel ? req_valid : 4'b0000;
    assign ack   = sel ? ack_b  : ack_a;
    assign din   = sel ? din_b  : din_a;
    assign wr_en = sel ? wr_b   : wr_a;
    assign gid   = sel ? gid_b  : gid_a;
    assign busy  = sel ? busy_b : busy_a;

    pcileech_com_tx_arbiter dut_a (
        .clk(clk), .rst(rst), .req_data(req_data), .req_valid(req_valid_a), .req_ack(ack_a),
        .com_din(din_a), .com_din_wr_en(wr_a), .com_din_ready(com_din_ready),
        .grant_id(gid_a), .busy(busy_a)
    );

    pcileech_com_tx_arbiter #(.PARAM_BURST(2), .PARAM_FLUSH_TICKS(16)) dut_b (
        .clk(clk), .rst(rst), .req_data(req_data), .req_valid(req_valid_b), .req_ack(ack_b),
        .com_din(din_b), .com_din_wr_en(wr_b), .com_din_ready(com_din_ready),
        .grant_id(gid_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    int           n_checks = 0;
    int           n_fail   = 0;
    int           cyc      = 0;
    int           n_wr     = 0;
    int           last_wr_cyc  = 0;
    int           last_ack_cyc = 0;
    int           ready_low    = 0;
    logic [31:0]  wq [4][$];
    logic [255:0] exp_q [$];
    logic [255:0] mpack = '0;
    int           mcnt  = 0;
    int           ack_log [$];
    int           rdy_log [$];
    vec_t         vecs [4];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic checki(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_accept(input logic [31:0] w);
        mpack[32*mcnt +: 32] = w;
        mcnt++;
        if (mcnt == 8) begin
            exp_q.push_back(mpack);
            mcnt = 0;
        end
    endtask

    task automatic expect_flush();
        for (int i = mcnt; i < 8; i++) mpack[32*i +: 32] = FILL;
        if (mcnt != 0) exp_q.push_back(mpack);
        mcnt = 0;
    endtask

    // One clock cycle: drive at the falling edge, sample the combinational ack 1ns later.
    task automatic step(input logic [3:0] v, input logic [127:0] d, output logic [3:0] a);
        @(negedge clk);
        cyc++;
        req_valid = v;
        req_data  = d;
        if (ready_low > 0) begin
            com_din_ready = 1'b0;
            ready_low--;
        end else begin
            com_din_ready = 1'b1;
        end
        #1;
        a = ack;
    endtask

    task automatic run_streams(input int budget);
        int          n = 0;
        logic [3:0]  v, a;
        logic [127:0] d;
        while ((wq[0].size() + wq[1].size() + wq[2].size() + wq[3].size()) > 0 && n < budget) begin
            v = '0;
            d = '0;
            for (int r = 0; r < 4; r++) begin
                if (wq[r].size() > 0) begin
                    v[r] = 1'b1;
                    d[32*r +: 32] = wq[r][0];
                end
            end
            step(v, d, a);
            if (a != 4'b0000) begin
                checki("ack_onehot", int'($onehot(a)), 1);
                checki("ack_without_valid", int'(a & ~v), 0);
                for (int r = 0; r < 4; r++) begin
                    if (a[r] && v[r]) begin
                        checki("ack_grant_id", int'(gid), r);
                        model_accept(wq[r].pop_front());
                        ack_log.push_back(r);
                        rdy_log.push_back(int'(com_din_ready));
                        last_ack_cyc = cyc;
                    end
                end
            end
            n++;
        end
        checki("stream_within_budget", int'(n < budget), 1);
    endtask

    task automatic drain(input int budget);
        int         n = 0;
        logic [3:0] a;
        while ((exp_q.size() > 0 || busy) && n < budget) begin
            step(4'b0000, '0, a);
            n++;
        end
        checki("drain_within_budget", int'(n < budget), 1);
    endtask

    // Scoreboard: every write must match the oldest pack the model has predicted.
    always @(negedge clk) begin
        #2;
        if (!rst && wr_en) begin
            n_wr++;
            last_wr_cyc = cyc;
            checki("wr_en_requires_ready", int'(com_din_ready), 1);
            if (exp_q.size() == 0) checki("unexpected_write", n_wr, 0);
            else check("com_din", din, exp_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]   a;
        logic [127:0] d;
        int           wr0;
        int           rid [$];
        int           rlen [$];

        rst = 1'b1; sel = 1'b0; req_valid = '0; req_data = '0; com_din_ready = 1'b1;
        vecs[0] = '{req: 0, base: 32'h0000_0000, exp_gid: 2'd0, exp_writes: 1};
        vecs[1] = '{req: 1, base: 32'hA000_0000, exp_gid: 2'd1, exp_writes: 1};
        vecs[2] = '{req: 3, base: 32'hFFFF_FFF0, exp_gid: 2'd3, exp_writes: 1};
        vecs[3] = '{req: 2, base: 32'h1234_5670, exp_gid: 2'd2, exp_writes: 1};

        repeat (3) step(4'b1111, '0, a);
        checki("rst_ack_gated", int'(a), 0);
        rst = 1'b0;
        step(4'b0000, '0, a);
        checki("reset_grant_a", int'(gid_a), 0);
        checki("reset_busy_a", int'(busy_a), 0);
        checki("reset_wr_a", int'(wr_a), 0);
        check("reset_din_a", din_a, '0);
        checki("reset_grant_b", int'(gid_b), 0);
        checki("reset_busy_b", int'(busy_b), 0);

        // Single-requester 8-word bursts on instance A; first row is 0x0..0x7 from requester 0.
        sel = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wr0 = n_wr;
            for (int k = 0; k < 8; k++) wq[vecs[i].req].push_back(vecs[i].base + 32'(k));
            run_streams(40);
            drain(20);
            checki("vec_grant_id", int'(gid), int'(vecs[i].exp_gid));
            checki("vec_write_count", n_wr - wr0, vecs[i].exp_writes);
        end

        // Output held off for 40 cycles while 16 words are offered.
        rdy_log.delete();
        ready_low = 40;
        wr0 = n_wr;
        for (int k = 0; k < 16; k++) wq[0].push_back(32'h3400_0000 + 32'(k));
        run_streams(100);
        checki("stall_ack_total", rdy_log.size(), 16);
        if (rdy_log.size() == 16) begin
            checki("fifteenth_ack_while_not_ready", rdy_log[14], 0);
            checki("lane7_ack_waits_for_ready", rdy_log[15], 1);
        end
        drain(30);
        checki("stall_write_count", n_wr - wr0, 2);

        // Reset with a full output register and five words in the pack.
        ready_low = 100;
        for (int k = 0; k < 13; k++) wq[0].push_back(32'h3600_0000 + 32'(k));
        run_streams(60);
        step(4'b0000, '0, a);
        checki("pre_reset_busy", int'(busy), 1);
        ready_low = 0;
        rst = 1'b1;
        d = '0;
        d[31:0] = 32'hDEAD_BEEF;
        step(4'b0001, d, a);
        checki("in_reset_ack", int'(a), 0);
        checki("in_reset_wr_en", int'(wr_en), 0);
        checki("in_reset_busy", int'(busy), 0);
        rst = 1'b0;
        exp_q.delete();
        mcnt = 0;
        step(4'b0000, '0, a);
        checki("post_reset_busy", int'(busy), 0);
        checki("post_reset_wr_en", int'(wr_en), 0);
        wr0 = n_wr;
        for (int k = 0; k < 8; k++) wq[0].push_back(32'h3700_0000 + 32'(k));
        run_streams(40);
        drain(20);
        checki("post_reset_write_count", n_wr - wr0, 1);

        // Instance B: all four requesters continuously valid, burst of 2.
        sel = 1'b1;
        ack_log.delete();
        wr0 = n_wr;
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 4; k++) wq[r].push_back((32'(r) << 28) | 32'(k));
        run_streams(120);
        drain(30);
        checki("rr_write_count", n_wr - wr0, 2);
        foreach (ack_log[i]) begin
            if (rid.size() == 0 || rid[rid.size()-1] != ack_log[i]) begin
                rid.push_back(ack_log[i]);
                rlen.push_back(1);
            end else begin
                rlen[rlen.size()-1]++;
            end
        end
        checki("rr_grant_count", rid.size(), 8);
        for (int k = 0; k < 5 && k < rid.size(); k++) begin
            checki("rr_order", rid[k], k % 4);
            checki("rr_words_per_grant", rlen[k], 2);
        end

        // Three words then silence: timer hits 15 on the 16th idle cycle, FLUSH the next,
        // output register loaded at that edge, write one cycle later.
        wr0 = n_wr;
        for (int k = 0; k < 3; k++) wq[1].push_back(32'hB000_0000 + 32'(k));
        run_streams(30);
        checki("flush_pending_busy", int'(busy), 1);
        expect_flush();
        drain(40);
        checki("flush_write_count", n_wr - wr0, 1);
        checki("flush_latency", last_wr_cyc - last_ack_cyc, 18);

        // Accept lands on the cycle the timer reaches threshold: no flush, timer restarts.
        wr0 = n_wr;
        wq[2].push_back(32'hC0DE_0001);
        run_streams(20);
        repeat (14) step(4'b0000, '0, a);
        d = '0;
        d[95:64] = 32'hC0DE_0002;
        step(4'b0100, d, a);
        checki("rearm_grant_cycle_no_ack", int'(a), 0);
        step(4'b0100, d, a);
        checki("accept_at_threshold", int'(a), 4);
        if (a[2]) begin
            model_accept(32'hC0DE_0002);
            last_ack_cyc = cyc;
        end
        expect_flush();
        drain(60);
        checki("threshold_write_count", n_wr - wr0, 1);
        checki("timer_restart_latency", last_wr_cyc - last_ack_cyc, 18);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
